// File: rtl/sim_memory_model_access_ctrl.sv
// sim_memory_model_access_ctrl
//
// Simulation memory back-end that sits directly after the request sync FIFO.
// It pops one request at a time and waits LATENCY cycles. A write is then
// committed to the internal word array. A read returns its data on a
// valid/busy response handshake. Only one request is ever outstanding.
//
// Ports
//   iCLOCK       system clock, all state on the rising edge
//   inRESET      asynchronous active-low reset
//   iREMOVE      synchronous flush, asserted in the same cycle as the FIFO flush
//   iREQ_EMPTY   request FIFO empty flag
//   iREQ_DATA    request word: {write, addr[AW-1:0], wdata[DW-1:0]}
//   oREQ_RD_EN   request FIFO pop (combinational)
//   oRESP_VALID  read response valid (registered)
//   oRESP_DATA   read response data (registered, keeps last value)
//   iRESP_BUSY   consumer back-pressure, response held while high
//   oBUSY        high whenever a request is being serviced
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request held; pops when FIFO non-empty and not flushing
// ST_WAIT | request latched, latency counter running down to 1
// ST_RESP | read data presented, waiting for iRESP_BUSY low

module sim_memory_model_access_ctrl #(
   parameter int AW      = 10,
   parameter int DW      = 32,
   parameter int LATENCY = 3
) (
   input  logic             iCLOCK,
   input  logic             inRESET,
   input  logic             iREMOVE,
   input  logic             iREQ_EMPTY,
   input  logic [AW+DW:0]   iREQ_DATA,
   output logic             oREQ_RD_EN,
   output logic             oRESP_VALID,
   output logic [DW-1:0]    oRESP_DATA,
   input  logic             iRESP_BUSY,
   output logic             oBUSY
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   localparam logic [7:0] LAT_LOAD = 8'(LATENCY);

   logic [1:0]    state;
   logic [7:0]    lat_cnt;
   logic [AW+DW:0] req_q;

   // Behaves like a power-up-cleared RAM: zeroed once, never touched by reset.
   logic [DW-1:0] mem [2**AW] = '{default: '0};

   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          access_edge;
   logic          mem_we;

   assign req_wr    = req_q[AW+DW];
   assign req_addr  = req_q[AW+DW-1:DW];
   assign req_wdata = req_q[DW-1:0];

   // Terminal count of the latency timer. A flush on this same edge wins, so
   // an in-flight write is dropped even on its commit edge.
   assign access_edge = (state == ST_WAIT) && (lat_cnt == 8'd1) && !iREMOVE;
   assign mem_we      = access_edge && req_wr;

   assign oREQ_RD_EN = (state == ST_IDLE) && !iREQ_EMPTY && !iREMOVE;
   assign oBUSY      = (state != ST_IDLE);

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state       <= ST_IDLE;
         lat_cnt     <= 8'd0;
         req_q       <= '0;
         oRESP_VALID <= 1'b0;
         oRESP_DATA  <= '0;
      end else if (iREMOVE) begin
         state       <= ST_IDLE;
         lat_cnt     <= 8'd0;
         oRESP_VALID <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!iREQ_EMPTY) begin
                  req_q   <= iREQ_DATA;
                  lat_cnt <= LAT_LOAD;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - 8'd1;
               if (access_edge) begin
                  if (req_wr) begin
                     state <= ST_IDLE;
                  end else begin
                     oRESP_DATA  <= mem[req_addr];
                     oRESP_VALID <= 1'b1;
                     state       <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (!iRESP_BUSY) begin
                  oRESP_VALID <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (mem_we) begin
         mem[req_addr] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_sim_memory_model_access_ctrl.sv
// Bench for sim_memory_model_access_ctrl.
// Three instances (LATENCY 3, 1, 255) share clock and reset. Each instance
// has its own request FIFO stand-in and response consumer. A word-array
// model of each instance predicts read data. Response and pop timing
// are predicted from edge counts.

module tb_sim_memory_model_access_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RW = AW + DW + 1;

   logic          iCLOCK = 1'b0;
   logic          inRESET = 1'b0;
   logic [2:0]    remove;
   logic [2:0]    req_empty;
   logic [2:0]    rd_en;
   logic [2:0]    resp_valid;
   logic [2:0]    resp_busy;
   logic [2:0]    busy;
   logic [RW-1:0] req_data [3];
   logic [DW-1:0] resp_data [3];

   always #5 iCLOCK = ~iCLOCK;

   sim_memory_model_access_ctrl #(.AW(AW), .DW(DW), .LATENCY(3)) u_lat3 (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(remove[0]),
      .iREQ_EMPTY(req_empty[0]), .iREQ_DATA(req_data[0]), .oREQ_RD_EN(rd_en[0]),
      .oRESP_VALID(resp_valid[0]), .oRESP_DATA(resp_data[0]),
      .iRESP_BUSY(resp_busy[0]), .oBUSY(busy[0]));

   sim_memory_model_access_ctrl #(.AW(AW), .DW(DW), .LATENCY(1)) u_lat1 (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(remove[1]),
      .iREQ_EMPTY(req_empty[1]), .iREQ_DATA(req_data[1]), .oREQ_RD_EN(rd_en[1]),
      .oRESP_VALID(resp_valid[1]), .oRESP_DATA(resp_data[1]),
      .iRESP_BUSY(resp_busy[1]), .oBUSY(busy[1]));

   sim_memory_model_access_ctrl #(.AW(AW), .DW(DW), .LATENCY(255)) u_lat255 (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(remove[2]),
      .iREQ_EMPTY(req_empty[2]), .iREQ_DATA(req_data[2]), .oREQ_RD_EN(rd_en[2]),
      .oRESP_VALID(resp_valid[2]), .oRESP_DATA(resp_data[2]),
      .iRESP_BUSY(resp_busy[2]), .oBUSY(busy[2]));

   int            checks = 0;
   int            failures = 0;
   int            pops [3] = '{0, 0, 0};
   logic [DW-1:0] mdl [3][1024];

   always @(posedge iCLOCK) begin
      for (int k = 0; k < 3; k++) begin
         if (rd_en[k]) pops[k] <= pops[k] + 1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic int lat_of(input int k);
      if (k == 0) return 3;
      if (k == 1) return 1;
      return 255;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge. Presents one request and waits for the pop edge.
   // Returns at the falling edge after the pop with the FIFO shown empty again.
   task automatic issue(input int k, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output time t0);
      int n;
      req_data[k]  = {wr, a, d};
      req_empty[k] = 1'b0;
      #1;
      n = 0;
      while (!rd_en[k] && n < 600) begin
         @(negedge iCLOCK);
         #1;
         n++;
      end
      chk("pop_seen", rd_en[k], 1);
      @(posedge iCLOCK);
      t0 = $time;
      @(negedge iCLOCK);
      req_empty[k] = 1'b1;
      req_data[k]  = RW'({$urandom, $urandom});
   endtask

   task automatic do_write(input int k, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output time t0);
      issue(k, 1'b1, a, d, t0);
      mdl[k][a] = d;
   endtask

   // Returns at the falling edge where the response is first seen if hold==0.
   // Otherwise holds the consumer busy for 'hold' cycles and returns after the handshake.
   task automatic do_read(input int k, input logic [AW-1:0] a, input int hold,
                          output time t0);
      int n;
      issue(k, 1'b0, a, DW'($urandom), t0);
      resp_busy[k] = 1'($urandom);
      n = 0;
      while (!resp_valid[k] && n < 600) begin
         @(negedge iCLOCK);
         n++;
      end
      chk("rd_valid_seen", resp_valid[k], 1);
      chk("rd_latency", ($time - t0 - 5) / 10, lat_of(k));
      chk("rd_data", resp_data[k], mdl[k][a]);
      chk("rd_busy_flag", busy[k], 1);
      resp_busy[k] = (hold > 0);
      if (hold > 0) begin
         req_empty[k] = 1'b0;
         req_data[k]  = RW'({$urandom, $urandom});
         for (int i = 0; i < hold; i++) begin
            @(negedge iCLOCK);
            chk("bp_valid_held", resp_valid[k], 1);
            chk("bp_data_held", resp_data[k], mdl[k][a]);
            chk("bp_no_pop", rd_en[k], 0);
         end
         resp_busy[k] = 1'b0;
         @(negedge iCLOCK);
         chk("hs_valid_clr", resp_valid[k], 0);
         chk("hs_data_kept", resp_data[k], mdl[k][a]);
         chk("hs_pop_ready", rd_en[k], 1);
         req_empty[k] = 1'b1;
      end
   endtask

   initial begin
      time t1, t2;
      int  p0, lat;
      logic [AW-1:0] pool [8];
      logic [AW-1:0] a;

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 1024; i++) mdl[k][i] = '0;
      for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
      pool[0] = '0;
      pool[7] = '1;

      // reset with random inputs
      req_empty = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge iCLOCK);
         remove    = 3'($urandom);
         resp_busy = 3'($urandom);
         for (int k = 0; k < 3; k++) req_data[k] = RW'({$urandom, $urandom});
         #1;
         for (int k = 0; k < 3; k++) begin
            chk("rst_valid", resp_valid[k], 0);
            chk("rst_data", resp_data[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_rd_en", rd_en[k], 0);
         end
      end
      @(negedge iCLOCK);
      inRESET   = 1'b1;
      remove    = '0;
      resp_busy = '0;
      @(negedge iCLOCK);
      chk("idle_empty_no_pop", rd_en[0], 0);

      // write then read, LATENCY=3
      p0 = pops[0];
      do_write(0, 10'h005, 32'hDEADBEEF, t1);
      do_read(0, 10'h005, 0, t2);
      chk("raw_pop_gap", (t2 - t1) / 10, 4);
      chk("raw_pop_count", pops[0] - p0, 2);

      // back-pressure, then next pop one cycle after the handshake
      do_write(0, 10'h0AA, 32'h0BAD_CAFE, t1);
      do_read(0, 10'h0AA, 5, t1);
      do_read(0, 10'h005, 0, t2);
      chk("bp_next_pop_gap", (t2 - t1) / 10, 3 + 5 + 2);

      // back-to-back reads
      do_read(0, 10'h0AA, 0, t1);
      do_read(0, 10'h005, 0, t2);
      chk("b2b_gap_lat3", (t2 - t1) / 10, 3 + 2);

      // flush on the write's commit edge discards it
      issue(0, 1'b1, 10'h010, 32'h1, t1);
      repeat (lat_of(0) - 1) @(negedge iCLOCK);
      remove[0] = 1'b1;
      @(negedge iCLOCK);
      chk("flush_wr_busy", busy[0], 0);
      remove[0] = 1'b0;
      do_read(0, 10'h010, 0, t1);

      // flush in RESP
      resp_busy[0] = 1'b1;
      remove[0]    = 1'b1;
      @(negedge iCLOCK);
      chk("flush_resp_valid", resp_valid[0], 0);
      chk("flush_resp_busy", busy[0], 0);
      remove[0]    = 1'b0;
      resp_busy[0] = 1'b0;

      // address extremes
      do_write(0, 10'h000, 32'hA5A5_0000, t1);
      do_write(0, 10'h3FF, 32'h5A5A_03FF, t1);
      do_read(0, 10'h000, 0, t1);
      do_read(0, 10'h3FF, 0, t1);

      // async reset in the middle of a write drops it
      do_write(0, 10'h123, 32'h1111_2222, t1);
      issue(0, 1'b1, 10'h123, 32'hCAFE_F00D, t1);
      inRESET = 1'b0;
      #1;
      chk("arst_valid", resp_valid[0], 0);
      chk("arst_data", resp_data[0], 0);
      chk("arst_busy", busy[0], 0);
      @(negedge iCLOCK);
      inRESET = 1'b1;
      do_read(0, 10'h123, 0, t1);

      // latency sweep on LATENCY=1 and 255
      for (int k = 1; k < 3; k++) begin
         lat = lat_of(k);
         do_write(k, 10'h3FF, DW'($urandom), t1);
         do_read(k, 10'h3FF, 0, t2);
         chk("sweep_raw_gap", (t2 - t1) / 10, lat + 1);
         do_write(k, 10'h000, DW'($urandom), t1);
         do_read(k, 10'h000, 0, t1);
         do_read(k, 10'h3FF, 0, t2);
         chk("sweep_b2b_gap", (t2 - t1) / 10, lat + 2);
      end

      // randomized traffic against the array model
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < ((k == 2) ? 8 : 50); i++) begin
            a = pool[$urandom_range(7, 0)];
            if ($urandom_range(1, 0) == 1) do_write(k, a, DW'($urandom), t1);
            else do_read(k, a, (k == 2) ? 0 : int'($urandom_range(3, 0)), t1);
         end
         repeat (lat_of(k) + 3) @(negedge iCLOCK);
         chk("rand_end_idle", busy[k], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
